pipelined_chunk_adder: RTL

//  Parametrised add/subtract unit for synth voice mixing and phase accumulation. Operand width is a

---
 rtl/synth_arith_pkg.sv | 35 +++
 rtl/chunk_adder_stage.sv | 25 ++
 rtl/pipelined_chunk_adder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/synth_arith_pkg.sv
// Shared arithmetic helpers for the synth voice datapath: stage-count and
// signed saturation limits expressed as width-parameterised functions.
package synth_arith_pkg;

    localparam int MAX_WIDTH = 64;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Number of CHUNK-bit carry stages needed to cover WIDTH bits.
    function automatic int num_stages(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 0;
    endfunction

    // Largest positive two's-complement value of the given width.
    function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of the given width.
    function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/chunk_adder_stage.sv
// Combinational CHUNK-bit ripple-carry adder built from one-bit full adders.
// The parent registers its outputs; this block holds no state.
module chunk_adder_stage #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out
);

    logic [CHUNK:0] carry;

    assign carry[0] = c_in;

    genvar i;
    for (i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[CHUNK];

endmodule

// File: rtl/pipelined_chunk_adder.sv
// Pipelined add/subtract unit: the carry chain is cut into CHUNK-bit stages,
// one stage per clock, with optional signed saturation on the final stage.
// The whole pipe advances together whenever the output slot is free or taken.
module pipelined_chunk_adder
    import synth_arith_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHUNK    = 4,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int STAGES = num_stages(WIDTH, CHUNK);
    localparam int PIPE   = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int LAST   = STAGES - 1;

    if (CHUNK < 1 || WIDTH < 1 || WIDTH > MAX_WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("pipelined_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    // Clamp to the signed limit in the direction of the operand sign.
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                  input logic             ovf,
                                                  input logic             neg);
        if (SATURATE != 0 && ovf)
            return neg ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH));
        return raw;
    endfunction

    logic adv;
    logic accept;

    // Per-stage combinational view: operands, carry-in and partial result
    logic [WIDTH-1:0] a_st   [STAGES];
    logic [WIDTH-1:0] b_st   [STAGES];
    logic [WIDTH-1:0] r_st   [STAGES];
    logic [WIDTH-1:0] r_nx   [STAGES];
    logic [CHUNK-1:0] s_st   [STAGES];
    logic             c_st   [STAGES];
    logic             co_st  [STAGES];
    logic             v_st   [STAGES];
    logic             sa_st  [STAGES];
    logic             sb_st  [STAGES];

    // Inter-stage pipeline registers (stage k output feeds stage k+1)
    logic [WIDTH-1:0] a_q    [PIPE];
    logic [WIDTH-1:0] b_q    [PIPE];
    logic [WIDTH-1:0] r_q    [PIPE];
    logic             c_q    [PIPE];
    logic             vld_q  [PIPE];
    logic             sa_q   [PIPE];
    logic             sb_q   [PIPE];

    // Output stage registers
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             c_out_q;
    logic             ovf_q;
    logic             ovf_d;
    logic [WIDTH-1:0] raw_d;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    // Stage 0 conditioning: subtract is a + ~b + ~borrow
    assign a_st[0]  = a;
    assign b_st[0]  = in_sub ? ~b : b;
    assign c_st[0]  = in_sub ^ c_in;
    assign r_st[0]  = '0;
    assign v_st[0]  = accept;
    assign sa_st[0] = a[WIDTH-1];
    assign sb_st[0] = in_sub ? ~b[WIDTH-1] : b[WIDTH-1];

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        if (k > 0) begin : g_link
            assign a_st[k]  = a_q[k-1];
            assign b_st[k]  = b_q[k-1];
            assign r_st[k]  = r_q[k-1];
            assign c_st[k]  = c_q[k-1];
            assign v_st[k]  = vld_q[k-1];
            assign sa_st[k] = sa_q[k-1];
            assign sb_st[k] = sb_q[k-1];
        end

        chunk_adder_stage #(.CHUNK(CHUNK)) u_add (
            .a     (CHUNK'(a_st[k] >> (k * CHUNK))),
            .b     (CHUNK'(b_st[k] >> (k * CHUNK))),
            .c_in  (c_st[k]),
            .sum   (s_st[k]),
            .c_out (co_st[k])
        );

        // Merge this stage's chunk into the completed lower result bits
        assign r_nx[k] = r_st[k] | (WIDTH'(s_st[k]) << (k * CHUNK));

        if (k < LAST) begin : g_reg
            // Stage valid bit: cleared on reset, shifts with the pipe
            always_ff @(posedge clk) begin
                if (reset)
                    vld_q[k] <= 1'b0;
                else if (adv)
                    vld_q[k] <= v_st[k];
            end

            // Stage data: operands, partial result, carry and sign bits
            always_ff @(posedge clk) begin
                if (adv) begin
                    a_q[k]  <= a_st[k];
                    b_q[k]  <= b_st[k];
                    r_q[k]  <= r_nx[k];
                    c_q[k]  <= co_st[k];
                    sa_q[k] <= sa_st[k];
                    sb_q[k] <= sb_st[k];
                end
            end
        end
    end

    // Final stage: signed overflow from carried sign bits, then saturate
    assign raw_d = r_nx[LAST];
    assign ovf_d = (sa_st[LAST] == sb_st[LAST]) && (raw_d[WIDTH-1] != sa_st[LAST]);
    assign sum_d = saturate(raw_d, ovf_d, sa_st[LAST]);

    // Output register: cleared on reset, holds while downstream stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= v_st[LAST];
            sum_q       <= sum_d;
            c_out_q     <= co_st[LAST];
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign overflow  = ovf_q;

endmodule
